// File: rtl/lsu_ctrl.sv
// Load/store controller: decodes one pipeline access at a time to data memory or
// to the output/input peripheral windows, and returns a single response strobe.
module lsu_ctrl #(
    parameter int unsigned DMEM_TIMEOUT = 15,
    parameter logic [31:0] OPER_BASE    = 32'h0000_7000,
    parameter logic [31:0] IPER_BASE    = 32'h0000_7800
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic [1:0]  addr_sel_o,
    input  logic [31:0] ld_data_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    output logic [3:0]  dmem_be_o,
    input  logic        dmem_rvalid_i,
    output logic        oper_we_o,
    output logic        iper_re_o,
    output logic [10:0] periph_addr_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PERIPH,
        S_DMEM_REQ,
        S_DMEM_WAIT,
        S_RESP
    } state_t;

    localparam logic [3:0]  TIMEOUT  = 4'(DMEM_TIMEOUT);
    localparam logic [31:0] WIN_SIZE = 32'h0000_0800;
    localparam logic [31:0] DMEM_TOP = 32'h0000_2000;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_nxt;
    logic [3:0]  be_q, cnt_q, cnt_nxt;
    logic [1:0]  sel_q, sel_dec;
    logic        we_q, err_q, err_nxt;
    logic        accept;

    always_comb begin
        sel_dec = 2'b01;
        if (req_addr_i < DMEM_TOP)
            sel_dec = 2'b00;
        else if (req_addr_i >= OPER_BASE && req_addr_i < OPER_BASE + WIN_SIZE)
            sel_dec = 2'b10;
        else if (req_addr_i >= IPER_BASE && req_addr_i < IPER_BASE + WIN_SIZE)
            sel_dec = 2'b11;
    end

    assign req_ready_o = (state == S_IDLE) && !rst_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt_q;
        rdata_nxt   = rdata_q;
        err_nxt     = err_q;
        dmem_req_o  = 1'b0;
        oper_we_o   = 1'b0;
        iper_re_o   = 1'b0;
        rsp_valid_o = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    rdata_nxt = '0;
                    err_nxt   = (sel_dec == 2'b01) || (req_be_i == 4'b0000);
                    // Errored accesses take the PERIPH slot with strobes suppressed,
                    // so every non-dmem response lands two cycles after accept.
                    if (sel_dec == 2'b00 && req_be_i != 4'b0000)
                        state_nxt = S_DMEM_REQ;
                    else
                        state_nxt = S_PERIPH;
                end
            end
            S_PERIPH: begin
                if (!err_q) begin
                    oper_we_o = we_q && (sel_q == 2'b10);
                    iper_re_o = !we_q && (sel_q == 2'b11);
                    if (!we_q)
                        rdata_nxt = ld_data_i;
                end
                state_nxt = S_RESP;
            end
            S_DMEM_REQ: begin
                dmem_req_o = 1'b1;
                cnt_nxt    = '0;
                if (dmem_rvalid_i) begin
                    if (!we_q)
                        rdata_nxt = ld_data_i;
                    state_nxt = S_RESP;
                end else begin
                    state_nxt = S_DMEM_WAIT;
                end
            end
            S_DMEM_WAIT: begin
                cnt_nxt = cnt_q + 4'd1;
                if (dmem_rvalid_i) begin
                    if (!we_q)
                        rdata_nxt = ld_data_i;
                    state_nxt = S_RESP;
                end else if (cnt_q == TIMEOUT) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            cnt_q   <= cnt_nxt;
            if (accept) begin
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
                be_q    <= req_be_i;
                we_q    <= req_we_i;
                sel_q   <= sel_dec;
            end
        end
    end

    assign busy_o        = (state != S_IDLE);
    assign addr_sel_o    = busy_o ? sel_q : 2'b00;
    assign dmem_we_o     = we_q;
    assign dmem_addr_o   = addr_q;
    assign dmem_wdata_o  = wdata_q;
    assign dmem_be_o     = be_q;
    assign periph_addr_o = addr_q[10:0];
    assign rsp_rdata_o   = (state == S_RESP) ? rdata_q : '0;
    assign rsp_err_o     = (state == S_RESP) && err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: directed accesses push expected responses,
// a negedge monitor pops and compares them when rsp_valid_o fires.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic [1:0]  addr_sel_o;
    logic [31:0] ld_data_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_rvalid_i;
    logic        oper_we_o;
    logic        iper_re_o;
    logic [10:0] periph_addr_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;

    lsu_ctrl #(
        .DMEM_TIMEOUT(15),
        .OPER_BASE   (32'h0000_7000),
        .IPER_BASE   (32'h0000_7800)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_be_i     (req_be_i),
        .addr_sel_o   (addr_sel_o),
        .ld_data_i    (ld_data_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_rvalid_i(dmem_rvalid_i),
        .oper_we_o    (oper_we_o),
        .iper_re_o    (iper_re_o),
        .periph_addr_o(periph_addr_o),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  sel;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid_o), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("rsp_rdata", rsp_rdata_o, mon_e.rdata);
                check("rsp_err", 32'(rsp_err_o), 32'(mon_e.err));
                check("rsp_sel", 32'(addr_sel_o), 32'(mon_e.sel));
            end
        end
    end

    // Returns at the negedge of cycle t+1, where t is the accept cycle.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int lat, input logic [31:0] er,
                         input logic ee, input logic [1:0] es, output int t);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!req_ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        t = cyc;
        if (lat > 0) begin
            e.cyc   = t + lat;
            e.rdata = er;
            e.err   = ee;
            e.sel   = es;
            sb.push_back(e);
        end
        @(negedge clk);
        req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int t;
        int pulses;
        rst_i         = 1'b1;
        req_valid_i   = 1'b0;
        req_we_i      = 1'b0;
        req_addr_i    = '0;
        req_wdata_i   = '0;
        req_be_i      = '0;
        ld_data_i     = '0;
        dmem_rvalid_i = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_sel", 32'(addr_sel_o), 32'd0);
        check("rst_dmem_req", 32'(dmem_req_o), 32'd0);
        check("rst_rdata", rsp_rdata_o, 32'd0);
        rst_i = 1'b0;
        #1 check("ready_after_rst", 32'(req_ready_o), 32'd1);

        // Input-peripheral load
        ld_data_i = 32'hA5A5_0001;
        issue(1'b0, 32'h0000_7804, 32'h0, 4'hF, 2, 32'hA5A5_0001, 1'b0, 2'b11, t);
        check("ipld_iper_re", 32'(iper_re_o), 32'd1);
        check("ipld_oper_we", 32'(oper_we_o), 32'd0);
        check("ipld_sel", 32'(addr_sel_o), 32'd3);
        check("ipld_paddr", 32'(periph_addr_o), 32'h004);
        drain();

        // Output-peripheral store
        issue(1'b1, 32'h0000_7000, 32'h55, 4'b0001, 2, 32'h0, 1'b0, 2'b10, t);
        check("opst_oper_we", 32'(oper_we_o), 32'd1);
        check("opst_paddr", 32'(periph_addr_o), 32'd0);
        check("opst_iper_re", 32'(iper_re_o), 32'd0);
        @(negedge clk);
        check("opst_oper_we_drop", 32'(oper_we_o), 32'd0);
        drain();

        // Data-memory load with rvalid three cycles after the request
        ld_data_i = 32'h1234_5678;
        issue(1'b0, 32'h0000_0100, 32'h0, 4'hF, 5, 32'h1234_5678, 1'b0, 2'b00, t);
        check("dmld_addr", dmem_addr_o, 32'h0000_0100);
        check("dmld_we", 32'(dmem_we_o), 32'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (dmem_req_o) pulses++;
            if (i == 1) check("dmld_busy_ready", 32'(req_ready_o), 32'd0);
            dmem_rvalid_i = (cyc == t + 4);
            @(negedge clk);
        end
        dmem_rvalid_i = 1'b0;
        check("dmld_pulses", 32'(pulses), 32'd1);
        drain();

        // Timeout: no rvalid, then a late ack that must be ignored
        ld_data_i = 32'hDEAD_BEEF;
        issue(1'b0, 32'h0000_0200, 32'h0, 4'hF, 18, 32'h0, 1'b1, 2'b00, t);
        pulses = 0;
        while (cyc < t + 24) begin
            if (dmem_req_o) pulses++;
            dmem_rvalid_i = (cyc == t + 20);
            @(negedge clk);
        end
        dmem_rvalid_i = 1'b0;
        check("tmo_pulses", 32'(pulses), 32'd1);
        drain();

        // Unmapped load
        ld_data_i = 32'hCAFE_F00D;
        issue(1'b0, 32'h0000_9000, 32'h0, 4'hF, 2, 32'h0, 1'b1, 2'b01, t);
        check("unm_iper_re", 32'(iper_re_o), 32'd0);
        check("unm_oper_we", 32'(oper_we_o), 32'd0);
        check("unm_dmem_req", 32'(dmem_req_o), 32'd0);
        check("unm_sel", 32'(addr_sel_o), 32'd1);
        drain();

        // Zero byte-enable store to dmem
        issue(1'b1, 32'h0000_0000, 32'h77, 4'b0000, 2, 32'h0, 1'b1, 2'b00, t);
        check("be0_dmem_req", 32'(dmem_req_o), 32'd0);
        @(negedge clk);
        check("be0_dmem_req_t2", 32'(dmem_req_o), 32'd0);
        drain();

        // Load from top of the output window returns ld_data_i
        ld_data_i = 32'h0BAD_0001;
        issue(1'b0, 32'h0000_77FF, 32'h0, 4'hF, 2, 32'h0BAD_0001, 1'b0, 2'b10, t);
        check("opld_oper_we", 32'(oper_we_o), 32'd0);
        check("opld_iper_re", 32'(iper_re_o), 32'd0);
        check("opld_paddr", 32'(periph_addr_o), 32'h7FF);
        drain();

        // Store to input window is dropped silently
        issue(1'b1, 32'h0000_7808, 32'h99, 4'hF, 2, 32'h0, 1'b0, 2'b11, t);
        check("ipst_iper_re", 32'(iper_re_o), 32'd0);
        check("ipst_oper_we", 32'(oper_we_o), 32'd0);
        drain();

        // Zero-wait dmem store at top of dmem range
        issue(1'b1, 32'h0000_1FFC, 32'h0BAD_CAFE, 4'b1100, 2, 32'h0, 1'b0, 2'b00, t);
        dmem_rvalid_i = 1'b1;
        check("zw_dmem_req", 32'(dmem_req_o), 32'd1);
        check("zw_we", 32'(dmem_we_o), 32'd1);
        check("zw_wdata", dmem_wdata_o, 32'h0BAD_CAFE);
        check("zw_be", 32'(dmem_be_o), 32'hC);
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        drain();

        // Decode boundaries just outside the mapped ranges
        issue(1'b0, 32'h0000_2000, 32'h0, 4'hF, 2, 32'h0, 1'b1, 2'b01, t);
        drain();
        issue(1'b0, 32'h0000_8000, 32'h0, 4'hF, 2, 32'h0, 1'b1, 2'b01, t);
        drain();

        // Reset during DMEM_WAIT aborts without a response
        issue(1'b0, 32'h0000_0300, 32'h0, 4'hF, 0, 32'h0, 1'b0, 2'b00, t);
        while (cyc < t + 3) @(negedge clk);
        check("abort_busy_before", 32'(busy_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_dmem_req", 32'(dmem_req_o), 32'd0);
        check("abort_rsp", 32'(rsp_valid_o), 32'd0);
        check("abort_ready_in_rst", 32'(req_ready_o), 32'd0);
        rst_i = 1'b0;
        #1 check("abort_ready", 32'(req_ready_o), 32'd1);

        repeat (20) @(negedge clk);
        check("final_queue", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
